// File: rtl/signmag_bcd_conv.sv
// signmag_bcd_conv: converts a two's-complement ALU result into sign,
// magnitude and packed BCD digits for the seven-segment driver.
// Binary-to-BCD uses a sequential shift-add-3 engine, one bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN: zero digits above the most
// significant non-zero digit are replaced by 4'hF (digit 0 never blanked).
module signmag_bcd_conv #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIGITS   = 5,
    parameter logic [2:0]  BOOL_OPT = 3'b101
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_data,
    input  logic [2:0]            opt,
    input  logic                  carry_flag,
    output logic                  busy,
    output logic                  done,
    output logic                  seg_sign,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [WIDTH-1:0]      ans_data,
    output logic                  ovf_flag
);

    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam int unsigned BW   = 4 * DIGITS;
    // Boolean mode looks at bit 8; narrow builds fall back to bit 0 only
    localparam int unsigned B8   = (WIDTH > 8) ? 8 : 0;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [2:0]        opt_q, opt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic              wsign_q, wsign_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              sign_q, sign_d;
    logic [WIDTH-1:0]  ans_q, ans_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     acc_corr;
    logic [3:0]        nib;

`ifdef LEADING_ZERO_BLANK_EN
    function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          lead;
        r    = v;
        lead = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (v[4*i +: 4] == 4'd0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction
`else
    function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
        return v;
    endfunction
`endif

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        acc_corr = '0;
        nib      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = acc_q[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            acc_corr[4*i +: 4] = nib;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        opt_d   = opt_q;
        carry_d = carry_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        wsign_d = wsign_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        ans_d   = ans_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d   = bin_data;
                    opt_d   = opt;
                    carry_d = carry_flag;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (opt_q == BOOL_OPT) begin
                    mag_d   = WIDTH'(bin_q[B8] | bin_q[0]);
                    wsign_d = 1'b0;
                end else if (bin_q[WIDTH-1]) begin
                    // Most-negative input negates to itself, read as unsigned
                    mag_d   = '0 - bin_q;
                    wsign_d = 1'b1;
                end else begin
                    mag_d   = bin_q;
                    wsign_d = 1'b0;
                end
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {acc_d, mag_d} = {acc_corr[BW-2:0], mag_q, 1'b0};
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Final shift result is registered straight into outputs
                    bcd_d   = blank_lz({acc_corr[BW-2:0], mag_q[WIDTH-1]});
                    sign_d  = wsign_q;
                    ans_d   = bin_q;
                    ovf_d   = carry_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            opt_q   <= '0;
            carry_q <= 1'b0;
            mag_q   <= '0;
            acc_q   <= '0;
            wsign_q <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ans_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            opt_q   <= opt_d;
            carry_q <= carry_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            wsign_q <= wsign_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            ans_q   <= ans_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign seg_sign = sign_q;
    assign bcd_out  = bcd_q;
    assign ans_data = ans_q;
    assign ovf_flag = ovf_q;

endmodule

// File: doc/signmag_bcd_conv.md
Name: signmag_bcd_conv

Overview:
Parametrised, handshaked successor to the result-conversion stage. It takes the ALU's two's-complement result and produces sign, magnitude and packed BCD digits for the seven-segment driver. The binary-to-BCD step is a sequential shift-add-3 engine, one bit per clock. It sits between the ALU result register and the display scanner, and supports any data width and digit count.

Parameters:
WIDTH, 16, data width of bin_data and ans_data
DIGITS, 5, number of BCD output digits; 10^DIGITS must exceed 2^(WIDTH-1)
BOOL_OPT, 3'b101, opt code selecting boolean/compare display mode

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request a conversion; sampled only in IDLE
bin_data  in  WIDTH  two's-complement ALU result
opt  in  3  operation code of the result
carry_flag  in  1  ALU carry/overflow flag
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when outputs update
seg_sign  out  1  1 = display minus sign
bcd_out  out  4*DIGITS  packed BCD magnitude, digit 0 in [3:0]
ans_data  out  WIDTH  raw bin_data captured at start, for chaining
ovf_flag  out  1  carry_flag captured at start

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - busy=0, done=0, seg_sign=0, bcd_out=0, ans_data=0, ovf_flag=0.
  - FSM goes to IDLE and the shift counter clears to 0.
- FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On start=1 at edge k, latch bin_data, opt and carry_flag, then go to LOAD.
  - If start=0, stay in IDLE.
- LOAD (one cycle): compute the working magnitude mag (WIDTH bits) and sign:
  - opt==BOOL_OPT: mag = 1 if bin_data[8] or bin_data[0] is set, else 0; sign=0.
  - otherwise, if bin_data[WIDTH-1]=1: mag = two's-complement negation, sign=1.
  - otherwise: mag = bin_data, sign=0.
  - Most-negative input 2^(WIDTH-1) gives mag=2^(WIDTH-1), read as unsigned, with no wrap.
  - Clear the BCD accumulator and go to SHIFT.
- SHIFT (exactly WIDTH cycles), each cycle:
  - Add 3 to every BCD nibble >= 5.
  - Shift {bcd, mag} left by 1.
  - Increment the counter; after the WIDTH-th shift go to DONE.
- DONE (one cycle): done=1.
  - bcd_out, seg_sign, ans_data and ovf_flag update on the edge that enters DONE.
  - Next state is IDLE.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH+1 (k+17 for WIDTH=16).
- Outputs hold their values until the next DONE or rst.
- Concurrent events:
  - start while busy=1, including the DONE cycle, is ignored and not queued.
  - Back-to-back: start may be re-asserted in the first IDLE cycle after DONE.
  - Input changes after start has been sampled have no effect on the conversion in flight.
- rst mid-conversion: abort on the next edge and apply all reset values; no done pulse.
- Width rule: the accumulator is 4*DIGITS bits; the add-3 correction applies to all DIGITS nibbles every cycle.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in the bcd_out value registered at DONE, every zero digit above the most significant non-zero digit is replaced by 4'hF (blank code for the segment decoder). Digit 0 is never blanked, so a value of 0 shows "0".
- Undefined: bcd_out carries raw BCD including leading zeros; no other behaviour changes.

Test Plan:
1. Positive value: bin_data=16'h0123, opt=000, start pulse -> done exactly 17 cycles after the start edge; bcd_out=20'h00291, seg_sign=0, ans_data=16'h0123.
2. Negative and most-negative: bin_data=16'hFF85 -> bcd_out=20'h00123, seg_sign=1, ans_data=16'hFF85. bin_data=16'h8000 -> bcd_out=20'h32768, seg_sign=1.
3. Boolean mode, opt=101:
   - bin_data=16'h0100 -> bcd_out=1, seg_sign=0.
   - bin_data=16'hFE00 -> 0.
   - bin_data=16'h0001 -> 1.
4. Handshake: start held high for 40 cycles with bin_data=9999 -> two conversions with done pulses 19 cycles apart; start changes during busy are ignored; carry_flag=1 at start -> ovf_flag=1.
5. Reset mid-operation: rst=1 at SHIFT cycle 8 -> next cycle busy=0, bcd_out=0, no done; a following start converts normally.
6. With LEADING_ZERO_BLANK_EN defined: bin_data=7 -> bcd_out=20'hFFFF7; 0 -> 20'hFFFF0; 16'hFF9C (-100) -> 20'hFF100, seg_sign=1.
